wb_rr_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one slave port, the ddr0 controller, among up to four bus masters: lm32 instruction, lm32 data, and two reserved slots for future DMA/video engines. It sits between the masters and the conbus slave-0 path. Grant is held for a master's whole `cyc` burst. A per-transfer watchdog converts a hung slave into a Wishbone error back to the requester.

---
 rtl/wb_rr_arbiter_if.sv | 38 +++
 rtl/wb_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the four-master request side and the single shared slave port of wb_rr_arbiter.
// Handshake: a master's cyc/stb act as valid; the slave's ack/err complete the beat in the cycle they are high.
interface wb_rr_arbiter_if;
  logic [127:0] m_adr_i;
  logic [127:0] m_dat_i;
  logic [15:0]  m_sel_i;
  logic [3:0]   m_we_i;
  logic [3:0]   m_cyc_i;
  logic [3:0]   m_stb_i;
  logic [31:0]  m_dat_o;
  logic [3:0]   m_ack_o;
  logic [3:0]   m_err_o;
  logic [31:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic         s_cyc_o;
  logic         s_stb_o;
  logic [31:0]  s_dat_i;
  logic         s_ack_i;
  logic         s_err_i;

  // slave: the arbiter's own view (it serves the masters and drives the shared slave port)
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );

  // master: the surrounding masters plus the downstream slave
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: four masters share the ddr0 slave port, grant held for a whole cyc burst,
// with a per-transfer watchdog that turns a hung slave into an err back to the requester.
module wb_rr_arbiter #(
  parameter int timeout_cycles = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_rr_arbiter_if.slave       bus,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [7:0]           timeout_cnt
);

  localparam int WD_W = (timeout_cycles > 256) ? $clog2(timeout_cycles) : 8;
  localparam int WD_LAST_INT = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_INT[WD_W-1:0];
  localparam bit WD_EN = (timeout_cycles != 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      tcnt_q, tcnt_d;

  logic [1:0]      rr_pick;
  logic [1:0]      rr_idx;
  logic            rr_found;
  logic            strobed;
  logic            wd_fire;

  // ptr resets to 3 so that master 0 is first in line after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'd0;
      ptr_q   <= 2'd3;
      wd_q    <= '0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    rr_pick  = ptr_q;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = ptr_q + 2'(i);
      if (!rr_found && bus.m_cyc_i[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.m_cyc_i) begin
          grant_d = rr_pick;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // stb may toggle within a burst; only cyc ends the tenure
        if (!bus.m_cyc_i[grant_q]) begin
          ptr_d   = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A master dropping cyc in the firing cycle is not strobed, so no err and no count
  always_comb begin
    strobed = (state_q == S_BUSY) && bus.m_cyc_i[grant_q] && bus.m_stb_i[grant_q];
    wd_fire = WD_EN && strobed && !bus.s_ack_i && !bus.s_err_i && (wd_q == WD_LAST);
    wd_d    = (!strobed || bus.s_ack_i || bus.s_err_i || wd_fire) ? '0 : wd_q + WD_W'(1);
    tcnt_d  = (wd_fire && tcnt_q != 8'hFF) ? tcnt_q + 8'd1 : tcnt_q;
  end

  always_comb begin
    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = 4'b0000;
    bus.m_err_o = 4'b0000;
    bus.s_adr_o = 32'd0;
    bus.s_dat_o = 32'd0;
    bus.s_sel_o = 4'b0000;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    if (state_q == S_BUSY) begin
      bus.s_adr_o          = bus.m_adr_i[{grant_q, 5'd0} +: 32];
      bus.s_dat_o          = bus.m_dat_i[{grant_q, 5'd0} +: 32];
      bus.s_sel_o          = bus.m_sel_i[{grant_q, 2'd0} +: 4];
      bus.s_we_o           = bus.m_we_i[grant_q];
      bus.s_cyc_o          = bus.m_cyc_i[grant_q];
      bus.s_stb_o          = bus.m_stb_i[grant_q];
      bus.m_ack_o[grant_q] = bus.s_ack_i;
      bus.m_err_o[grant_q] = bus.s_err_i | wd_fire;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == S_BUSY);
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus randomized masters checked against a cycle-level model.
module tb_wb_rr_arbiter;
  logic       clk;
  logic       rst;
  logic       ack_en;
  logic [1:0] grant, grant0;
  logic       busy, busy0;
  logic [7:0] tcnt, tcnt0;
  int         n_checks = 0;
  int         n_pass = 0;

  wb_rr_arbiter_if bus ();
  wb_rr_arbiter_if bus0 ();

  // Slave acks any strobed beat while ack_en is high; a second copy runs with the watchdog disabled
  assign bus.s_ack_i  = bus.s_cyc_o & bus.s_stb_o & ack_en;
  assign bus0.m_adr_i = bus.m_adr_i;
  assign bus0.m_dat_i = bus.m_dat_i;
  assign bus0.m_sel_i = bus.m_sel_i;
  assign bus0.m_we_i  = bus.m_we_i;
  assign bus0.m_cyc_i = bus.m_cyc_i;
  assign bus0.m_stb_i = bus.m_stb_i;
  assign bus0.s_dat_i = bus.s_dat_i;
  assign bus0.s_ack_i = bus.s_ack_i;
  assign bus0.s_err_i = bus.s_err_i;

  wb_rr_arbiter #(.timeout_cycles(16)) dut (
    .clk(clk), .reset(rst), .bus(bus), .grant(grant), .busy(busy), .timeout_cnt(tcnt)
  );

  wb_rr_arbiter #(.timeout_cycles(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0), .grant(grant0), .busy(busy0), .timeout_cnt(tcnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t want < 500000", $time);
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_we_i  = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.s_dat_i = '0;
    bus.s_err_i = 1'b0;
    ack_en      = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (grant !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant); else n_pass++;
    n_checks++; if (bus.s_cyc_o !== 1'b0) $display("FAIL reset_s_cyc: got %0b want 0", bus.s_cyc_o); else n_pass++;
    n_checks++; if (tcnt !== 8'd0) $display("FAIL reset_tcnt: got %0d want 0", tcnt); else n_pass++;
    bus.m_cyc_i = 4'b0100;
    bus.m_stb_i = 4'b0100;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || grant !== 2'd2) $display("FAIL reset_pre_grant: got busy=%0b grant=%0d want 1/2", busy, grant); else n_pass++;
    n_checks++; if (bus.m_ack_o !== 4'b0100) $display("FAIL reset_pre_ack: got %b want 0100", bus.m_ack_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.s_cyc_o !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid_burst: got s_cyc=%0b busy=%0b want 0/0", bus.s_cyc_o, busy); else n_pass++;
    n_checks++; if (grant !== 2'd0 || bus.m_ack_o !== 4'b0000) $display("FAIL reset_mid_grant: got grant=%0d ack=%b want 0/0000", grant, bus.m_ack_o); else n_pass++;
    bus.m_cyc_i = 4'b1111;
    bus.m_stb_i = 4'b1111;
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || grant !== 2'd0) $display("FAIL reset_first_winner: got busy=%0b grant=%0d want 1/0", busy, grant); else n_pass++;
  endtask

  task automatic test_round_robin();
    int        order[$];
    bit        drop[4];
    int        rem[4];
    int        session_acks, idle_len;
    bit        prev_busy;
    logic [3:0] cyc_v;
    apply_reset();
    for (int k = 0; k < 4; k++) begin drop[k] = 1'b0; rem[k] = 4; end
    session_acks = 0;
    idle_len = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      for (int k = 0; k < 4; k++) cyc_v[k] = !drop[k];
      bus.m_cyc_i = cyc_v;
      bus.m_stb_i = cyc_v;
      #1;
      if (busy && !prev_busy) begin
        if (order.size() > 0) begin
          n_checks++; if (idle_len !== 1) $display("FAIL rr_dead_cycle: got %0d idle cycles want 1", idle_len); else n_pass++;
        end
        order.push_back(int'(grant));
        idle_len = 0;
      end
      if (!busy && prev_busy) begin
        n_checks++; if (session_acks !== 4) $display("FAIL rr_burst_acks: got %0d want 4", session_acks); else n_pass++;
        session_acks = 0;
      end
      if (!busy) begin
        idle_len++;
        n_checks++; if (bus.s_cyc_o !== 1'b0) $display("FAIL rr_idle_cyc: got %0b want 0", bus.s_cyc_o); else n_pass++;
      end else begin
        session_acks += $countones(bus.m_ack_o);
      end
      prev_busy = busy;
      for (int k = 0; k < 4; k++) begin
        if (drop[k]) drop[k] = 1'b0;
        else if (bus.m_ack_o[k]) begin
          rem[k]--;
          if (rem[k] == 0) begin drop[k] = 1'b1; rem[k] = 4; end
        end
      end
      @(negedge clk);
    end
    n_checks++; if (order.size() !== 5) $display("FAIL rr_grant_count: got %0d grants want 5", order.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ((i < order.size() ? order[i] : -1) !== i % 4)
        $display("FAIL rr_order_%0d: got %0d want %0d", i, (i < order.size() ? order[i] : -1), i % 4);
      else n_pass++;
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    bus.m_adr_i[63:32] = 32'h4000_0010;
    bus.m_cyc_i = 4'b0010;
    bus.m_stb_i = 4'b0010;
    bus.s_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    n_checks++; if (bus.m_dat_o !== 32'hDEAD_BEEF) $display("FAIL read_dat: got %h want deadbeef", bus.m_dat_o); else n_pass++;
    n_checks++; if (bus.m_ack_o !== 4'b0010) $display("FAIL read_ack: got %b want 0010", bus.m_ack_o); else n_pass++;
    n_checks++; if (bus.s_adr_o !== 32'h4000_0010) $display("FAIL read_adr: got %h want 40000010", bus.s_adr_o); else n_pass++;
    n_checks++; if (bus.s_we_o !== 1'b0 || grant !== 2'd1) $display("FAIL read_we_grant: got we=%0b grant=%0d want 0/1", bus.s_we_o, grant); else n_pass++;
  endtask

  task automatic test_write();
    logic [31:0] wdat;
    apply_reset();
    wdat = $urandom;
    bus.m_dat_i = {$urandom, $urandom, $urandom, $urandom};
    bus.m_dat_i[95:64] = wdat;
    bus.m_sel_i = 16'hFFFF;
    bus.m_sel_i[11:8] = 4'b0011;
    bus.m_we_i  = 4'b0100;
    bus.m_cyc_i = 4'b0100;
    bus.m_stb_i = 4'b0100;
    @(negedge clk);
    #1;
    n_checks++; if (bus.s_we_o !== 1'b1) $display("FAIL write_we: got %0b want 1", bus.s_we_o); else n_pass++;
    n_checks++; if (bus.s_sel_o !== 4'b0011) $display("FAIL write_sel: got %b want 0011", bus.s_sel_o); else n_pass++;
    n_checks++; if (bus.s_dat_o !== wdat) $display("FAIL write_dat: got %h want %h", bus.s_dat_o, wdat); else n_pass++;
    n_checks++; if (bus.m_ack_o !== 4'b0100) $display("FAIL write_ack: got %b want 0100", bus.m_ack_o); else n_pass++;
  endtask

  task automatic test_watchdog();
    int err_q[$];
    int errs0;
    apply_reset();
    ack_en = 1'b0;
    bus.m_cyc_i = 4'b0001;
    bus.m_stb_i = 4'b0001;
    errs0 = 0;
    @(negedge clk);
    for (int i = 0; i < 41; i++) begin
      #1;
      if (bus.m_err_o !== 4'b0000) begin
        err_q.push_back(i);
        n_checks++; if (bus.m_err_o !== 4'b0001) $display("FAIL wd_err_mask: got %b want 0001", bus.m_err_o); else n_pass++;
      end
      if (bus0.m_err_o !== 4'b0000) errs0++;
      if (i == 16) begin
        n_checks++; if (tcnt !== 8'd1) $display("FAIL wd_tcnt_first: got %0d want 1", tcnt); else n_pass++;
      end
      if (i == 32) begin
        n_checks++; if (tcnt !== 8'd2) $display("FAIL wd_tcnt_second: got %0d want 2", tcnt); else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++; if (err_q.size() !== 2) $display("FAIL wd_pulse_count: got %0d want 2", err_q.size()); else n_pass++;
    n_checks++; if ((err_q.size() > 0 ? err_q[0] : -1) !== 15) $display("FAIL wd_first_pulse: got cycle %0d want 15", (err_q.size() > 0 ? err_q[0] : -1)); else n_pass++;
    n_checks++; if ((err_q.size() > 1 ? err_q[1] : -1) !== 31) $display("FAIL wd_second_pulse: got cycle %0d want 31", (err_q.size() > 1 ? err_q[1] : -1)); else n_pass++;
    n_checks++; if (errs0 !== 0 || tcnt0 !== 8'd0) $display("FAIL wd_disabled: got errs=%0d tcnt=%0d want 0/0", errs0, tcnt0); else n_pass++;
  endtask

  task automatic test_err_coincide();
    int errs;
    apply_reset();
    ack_en = 1'b0;
    bus.m_cyc_i = 4'b0001;
    bus.m_stb_i = 4'b0001;
    errs = 0;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      bus.s_err_i = (i == 15);
      #1;
      if (bus.m_err_o !== 4'b0000) errs++;
      if (i == 15) begin
        n_checks++; if (bus.m_err_o !== 4'b0001) $display("FAIL coincide_err: got %b want 0001", bus.m_err_o); else n_pass++;
      end
      @(negedge clk);
    end
    bus.s_err_i = 1'b0;
    n_checks++; if (errs !== 1) $display("FAIL coincide_pulses: got %0d want 1", errs); else n_pass++;
    n_checks++; if (tcnt !== 8'd0) $display("FAIL coincide_tcnt: got %0d want 0", tcnt); else n_pass++;
  endtask

  task automatic test_drop_at_fire();
    int errs;
    apply_reset();
    ack_en = 1'b0;
    bus.m_cyc_i = 4'b0001;
    bus.m_stb_i = 4'b0001;
    errs = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        bus.m_cyc_i = 4'b0000;
        bus.m_stb_i = 4'b0000;
      end
      #1;
      if (bus.m_err_o !== 4'b0000) errs++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (errs !== 0) $display("FAIL drop_fire_err: got %0d pulses want 0", errs); else n_pass++;
    n_checks++; if (tcnt !== 8'd0 || busy !== 1'b0) $display("FAIL drop_fire_state: got tcnt=%0d busy=%0b want 0/0", tcnt, busy); else n_pass++;
  endtask

  task automatic test_saturate();
    int pulses;
    apply_reset();
    ack_en = 1'b0;
    bus.m_cyc_i = 4'b0001;
    bus.m_stb_i = 4'b0001;
    pulses = 0;
    @(negedge clk);
    for (int c = 0; c < 6000 && pulses < 300; c++) begin
      #1;
      if (bus.m_err_o[0]) pulses++;
      if (pulses == 100 && bus.m_err_o[0]) begin
        n_checks++; if (tcnt !== 8'd99) $display("FAIL sat_mid: got %0d want 99", tcnt); else n_pass++;
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (pulses !== 300) $display("FAIL sat_pulses: got %0d want 300", pulses); else n_pass++;
    n_checks++; if (tcnt !== 8'd255) $display("FAIL sat_tcnt: got %0d want 255", tcnt); else n_pass++;
  endtask

  // Model: owner of the bus (-1 when idle), rotation pointer, and consecutive unanswered strobe cycles
  task automatic test_random();
    int          owner, ptr, last_g, stall, tcnt_m, o, idx;
    bit          active[4], cool[4];
    int          rem[4];
    logic [31:0] adr[4], dat[4];
    logic [3:0]  sel[4];
    logic        we[4];
    logic [3:0]  cyc_v, stb_v, exp_ack, exp_err;
    logic [70:0] exp_s, act_s;
    logic        a, e, fire;
    logic [31:0] sdat;
    apply_reset();
    owner = -1; ptr = 3; last_g = 0; stall = 0; tcnt_m = 0;
    for (int k = 0; k < 4; k++) begin
      active[k] = 1'b0; cool[k] = 1'b0; rem[k] = 0;
      adr[k] = '0; dat[k] = '0; sel[k] = '0; we[k] = 1'b0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (cool[k]) cool[k] = 1'b0;
        else if (!active[k] && $urandom_range(0, 3) == 0) begin
          active[k] = 1'b1;
          rem[k] = $urandom_range(1, 5);
          adr[k] = $urandom;
          sel[k] = 4'($urandom_range(0, 15));
          we[k]  = 1'($urandom_range(0, 1));
        end
        dat[k] = $urandom;
        cyc_v[k] = active[k];
        stb_v[k] = active[k] && ($urandom_range(0, 4) != 0);
        bus.m_adr_i[32*k +: 32] = adr[k];
        bus.m_dat_i[32*k +: 32] = dat[k];
        bus.m_sel_i[4*k +: 4]   = sel[k];
        bus.m_we_i[k]           = we[k];
      end
      bus.m_cyc_i = cyc_v;
      bus.m_stb_i = stb_v;
      ack_en = ((c % 400) < 100) ? 1'b0 : 1'($urandom_range(0, 9) < 7);
      e = ($urandom_range(0, 24) == 0);
      bus.s_err_i = e;
      sdat = $urandom;
      bus.s_dat_i = sdat;
      #1;
      exp_s = '0; exp_ack = '0; exp_err = '0; a = 1'b0; fire = 1'b0;
      if (owner >= 0) begin
        o = owner;
        a = cyc_v[o] & stb_v[o] & ack_en;
        fire = (stall == 15) && cyc_v[o] && stb_v[o] && !a && !e;
        exp_s = {adr[o], dat[o], sel[o], we[o], cyc_v[o], stb_v[o]};
        exp_ack[o] = a;
        exp_err[o] = e | fire;
      end
      act_s = {bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_cyc_o, bus.s_stb_o};
      n_checks++; if (act_s !== exp_s) $display("FAIL rand_slave_side c=%0d: got %h want %h", c, act_s, exp_s); else n_pass++;
      n_checks++; if (bus.m_ack_o !== exp_ack || bus.m_err_o !== exp_err)
        $display("FAIL rand_resp c=%0d: got ack=%b err=%b want ack=%b err=%b", c, bus.m_ack_o, bus.m_err_o, exp_ack, exp_err); else n_pass++;
      n_checks++; if (busy !== (owner >= 0) || grant !== 2'(last_g) || tcnt !== 8'(tcnt_m))
        $display("FAIL rand_status c=%0d: got busy=%0b grant=%0d tcnt=%0d want %0b/%0d/%0d", c, busy, grant, tcnt, (owner >= 0), last_g, tcnt_m); else n_pass++;
      n_checks++; if (bus.m_dat_o !== sdat) $display("FAIL rand_rdata c=%0d: got %h want %h", c, bus.m_dat_o, sdat); else n_pass++;
      for (int k = 0; k < 4; k++) begin
        if (active[k] && bus.m_ack_o[k]) rem[k]--;
        if (active[k] && (rem[k] <= 0 || bus.m_err_o[k])) begin
          active[k] = 1'b0;
          cool[k] = 1'b1;
        end
      end
      if (owner < 0) begin
        if (|cyc_v) begin
          for (int i = 4; i >= 1; i--) begin
            idx = (ptr + i) % 4;
            if (cyc_v[idx]) owner = idx;
          end
          last_g = owner;
        end
        stall = 0;
      end else if (!cyc_v[owner]) begin
        ptr = owner;
        owner = -1;
        stall = 0;
      end else begin
        if (!stb_v[owner] || a || e || fire) stall = 0;
        else stall++;
        if (fire && tcnt_m < 255) tcnt_m++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_watchdog();
    test_err_coincide();
    test_drop_at_fire();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
